// File: rtl/riscv_state_dump.sv
`timescale 1ns/1ps
// riscv_state_dump
//   Post-run readout engine for the pipelined RISC-V core. A start pulse
//   freezes the core (halt_req), waits DRAIN_CYCLES for the pipeline to
//   empty, then streams all NUM_REGS architectural registers followed by
//   MEM_WORDS data-memory words starting at MEM_BASE.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           one-cycle dump request, sampled only in IDLE
//   busy            high in every state except IDLE
//   done            one-cycle pulse after the final word's handshake
//   halt_req        core stall request, DRAIN through the last handshake
//   reg_raddr/rdata register-file debug port (combinational read)
//   dmem_raddr/rdata data-memory port (read data one cycle after address)
//   out_*           dump stream: data, is_mem flag, index, last flag
//   dbg_state       current FSM state encoding, for checkers
//
// Stream handshake: a word transfers on a rising edge where
// out_valid && out_ready. out_valid comes straight from a flop; once set it
// stays high, with out_data/out_index/out_is_mem/out_last frozen, until that
// transfer happens. out_ready feeds only next-state logic.
module riscv_state_dump #(
  parameter int NUM_REGS     = 32,
  parameter int MEM_BASE     = 0,
  parameter int MEM_WORDS    = 16,
  parameter int DRAIN_CYCLES = 5,   // must be >= 1
  parameter int AW           = 10   // must be >= 5 so a register number fits
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          halt_req,
  output logic [4:0]    reg_raddr,
  input  logic [31:0]   reg_rdata,
  output logic [AW-1:0] dmem_raddr,
  input  logic [31:0]   dmem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_is_mem,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_REG_RD  = 3'd2,
    S_REG_OUT = 3'd3,
    S_MEM_RD  = 3'd4,
    S_MEM_CAP = 3'd5,
    S_MEM_OUT = 3'd6,
    S_FIN     = 3'd7
  } state_e;

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [AW-1:0] REG_LAST   = AW'(NUM_REGS - 1);
  // With MEM_WORDS == 0 this value is never compared against.
  localparam logic [AW-1:0] MEM_LAST   = AW'(MEM_WORDS - 1);
  localparam logic [AW-1:0] BASE_A     = AW'(MEM_BASE);
  localparam bit            HAS_MEM    = (MEM_WORDS > 0);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [4:0]    reg_raddr_q, reg_raddr_d;
  logic [AW-1:0] dmem_raddr_q, dmem_raddr_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          is_mem_q, is_mem_d;
  logic [AW-1:0] index_q, index_d;
  logic          last_q, last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      cnt_q        <= '0;
      reg_raddr_q  <= '0;
      dmem_raddr_q <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      is_mem_q     <= 1'b0;
      index_q      <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      cnt_q        <= cnt_d;
      reg_raddr_q  <= reg_raddr_d;
      dmem_raddr_q <= dmem_raddr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      is_mem_q     <= is_mem_d;
      index_q      <= index_d;
      last_q       <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    cnt_d        = cnt_q;
    reg_raddr_d  = reg_raddr_q;
    dmem_raddr_d = dmem_raddr_q;
    valid_d      = valid_q;
    data_d       = data_q;
    is_mem_d     = is_mem_q;
    index_d      = index_q;
    last_d       = last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_DRAIN;
          drain_d     = '0;
          cnt_d       = '0;
          reg_raddr_d = '0;
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_REG_RD;
        else                       drain_d = drain_q + DW'(1);
      end

      // reg_raddr already equals the counter; the register file answers
      // in this same cycle, so the word is captured here.
      S_REG_RD: begin
        data_d   = reg_rdata;
        index_d  = cnt_q;
        is_mem_d = 1'b0;
        last_d   = (cnt_q == REG_LAST) && !HAS_MEM;
        valid_d  = 1'b1;
        state_d  = S_REG_OUT;
      end

      S_REG_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (cnt_q == REG_LAST) begin
            cnt_d = '0;
            if (HAS_MEM) begin
              // Address is presented on entry to MEM_RD so the synchronous
              // memory returns data during MEM_CAP.
              dmem_raddr_d = BASE_A;
              state_d      = S_MEM_RD;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            cnt_d       = cnt_q + AW'(1);
            reg_raddr_d = reg_raddr_q + 5'd1;
            state_d     = S_REG_RD;
          end
        end
      end

      S_MEM_RD: state_d = S_MEM_CAP;

      S_MEM_CAP: begin
        data_d   = dmem_rdata;
        index_d  = cnt_q;
        is_mem_d = 1'b1;
        last_d   = (cnt_q == MEM_LAST);
        valid_d  = 1'b1;
        state_d  = S_MEM_OUT;
      end

      S_MEM_OUT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (cnt_q == MEM_LAST) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
            // AW-bit sum: the window wraps past the top of memory.
            dmem_raddr_d = BASE_A + cnt_q + AW'(1);
            state_d      = S_MEM_RD;
          end
        end
      end

      S_FIN:   state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign halt_req   = (state_q != S_IDLE) && (state_q != S_FIN);
  assign reg_raddr  = reg_raddr_q;
  assign dmem_raddr = dmem_raddr_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_is_mem = is_mem_q;
  assign out_index  = index_q;
  assign out_last   = last_q;
  assign dbg_state  = state_q;

endmodule
